// File: rtl/biriscv_mul_wb_tracker_if.sv
// Issue, decode, multiplier-result and writeback/hazard signals shared between
// the issue stage and the multiply writeback tracker.
interface biriscv_mul_wb_tracker_if;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_idx_i;
    logic [31:0] issue_pc_i;
    logic [4:0]  dec_ra_idx_i;
    logic [4:0]  dec_rb_idx_i;
    logic [4:0]  dec_rc_idx_i;
    logic        dec_rc_used_i;
    logic [31:0] mult_value_i;

    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_value_o;
    logic        stall_o;
    logic        byp_a_o;
    logic        byp_b_o;
    logic        byp_c_o;
    logic [31:0] byp_value_o;

    modport master (
        output issue_valid_i, issue_rd_idx_i, issue_pc_i,
        output dec_ra_idx_i, dec_rb_idx_i, dec_rc_idx_i, dec_rc_used_i,
        output mult_value_i,
        input  wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o,
        input  stall_o, byp_a_o, byp_b_o, byp_c_o, byp_value_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_idx_i, issue_pc_i,
        input  dec_ra_idx_i, dec_rb_idx_i, dec_rc_idx_i, dec_rc_used_i,
        input  mult_value_i,
        output wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o,
        output stall_o, byp_a_o, byp_b_o, byp_c_o, byp_value_o
    );
endinterface

// File: rtl/biriscv_mul_wb_tracker.sv
// Shadow pipeline tracking rd/PC of in-flight multiplies, producing the tagged
// writeback and the RAW stall/bypass decisions for the instruction in issue.
module biriscv_mul_wb_tracker #(
    parameter int unsigned MULT_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       hold_i,
    input  logic                       flush_i,
    biriscv_mul_wb_tracker_if.slave    bus,
    output logic [1:0]                 inflight_o,
    output logic [31:0]                stall_cnt_o
);

    localparam int unsigned Last = MULT_STAGES - 1;

    logic [MULT_STAGES-1:0]        vld_q, vld_d;
    logic [MULT_STAGES-1:0][4:0]   rd_q, rd_d;
    logic [MULT_STAGES-1:0][31:0]  pc_q, pc_d;
    logic [31:0]                   stall_cnt_q, stall_cnt_d;

    logic [2:0][4:0] src_idx;
    logic [2:0]      src_en;
    logic [2:0]      src_stall;
    logic [2:0]      src_byp;
    logic            stall;
    logic [1:0]      inflight;

    assign src_idx = {bus.dec_rc_idx_i, bus.dec_rb_idx_i, bus.dec_ra_idx_i};
    assign src_en  = {bus.dec_rc_used_i, 1'b1, 1'b1};

    // Walk from oldest to youngest so the youngest matching stage wins (WAW-safe).
    always_comb begin
        src_stall = '0;
        src_byp   = '0;
        for (int s = 0; s < 3; s++) begin
            for (int k = int'(Last); k >= 0; k--) begin
                if (src_en[s] && (src_idx[s] != 5'd0) && vld_q[k] && (rd_q[k] == src_idx[s])) begin
                    src_stall[s] = (k != int'(Last));
                    src_byp[s]   = (k == int'(Last));
                end
            end
        end
    end

    assign stall = |src_stall;

    always_comb begin
        inflight = 2'd0;
        for (int k = 0; k < int'(MULT_STAGES); k++) begin
            inflight = inflight + {1'b0, vld_q[k]};
        end
    end

    always_comb begin
        vld_d       = vld_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold_i) begin
            vld_d[0] = bus.issue_valid_i;
            rd_d[0]  = bus.issue_rd_idx_i;
            pc_d[0]  = bus.issue_pc_i;
            for (int k = 1; k < int'(MULT_STAGES); k++) begin
                vld_d[k] = vld_q[k-1];
                rd_d[k]  = rd_q[k-1];
                pc_d[k]  = pc_q[k-1];
            end
            if (stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
        // Flush wins over hold and also drops an op issued this cycle.
        if (flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q       <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.wb_valid_o  = vld_q[Last] & (rd_q[Last] != 5'd0);
    assign bus.wb_rd_idx_o = rd_q[Last];
    assign bus.wb_pc_o     = pc_q[Last];
    assign bus.wb_value_o  = bus.mult_value_i;
    assign bus.stall_o     = stall;
    assign bus.byp_a_o     = src_byp[0] & ~stall;
    assign bus.byp_b_o     = src_byp[1] & ~stall;
    assign bus.byp_c_o     = src_byp[2] & ~stall;
    assign bus.byp_value_o = bus.mult_value_i;
    assign inflight_o      = inflight;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_biriscv_mul_wb_tracker.sv
// Bench for biriscv_mul_wb_tracker: directed table, hand-written hold/flush/reset/wrap
// sequences, then randomized traffic against an op-queue reference model.
module tb_biriscv_mul_wb_tracker;

    localparam int N = 2;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        flush;
    logic [1:0]  inflight;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    biriscv_mul_wb_tracker_if bus();

    biriscv_mul_wb_tracker #(.MULT_STAGES(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .hold_i      (hold),
        .flush_i     (flush),
        .bus         (bus),
        .inflight_o  (inflight),
        .stall_cnt_o (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid_i  = 1'b0;
        bus.issue_rd_idx_i = 5'd0;
        bus.issue_pc_i     = 32'd0;
        bus.dec_ra_idx_i   = 5'd0;
        bus.dec_rb_idx_i   = 5'd0;
        bus.dec_rc_idx_i   = 5'd0;
        bus.dec_rc_used_i  = 1'b0;
        bus.mult_value_i   = 32'd0;
        hold               = 1'b0;
        flush              = 1'b0;
    endtask

    // Directed vector: inputs for one cycle and the outputs expected in that cycle.
    typedef struct packed {
        logic        iv;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic        rcu;
        logic [31:0] mv;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic        e_st;
        logic        e_ba;
        logic        e_bb;
        logic        e_bc;
        logic [1:0]  e_inf;
    } vec_t;

    vec_t vecs[17];

    // Reference model: a queue of in-flight ops, each tagged with its age in cycles.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] pc;
        int          age;
    } op_t;

    op_t         q[$];
    logic [31:0] m_cnt;

    function automatic int youngest_age(input logic [4:0] idx, input bit en);
        int best = N + 1;
        if (en && idx != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == idx && q[i].age < best) best = q[i].age;
            end
        end
        return best;
    endfunction

    task automatic model_check();
        int  ya, yb, yc;
        bit  st, found;
        logic [4:0]  wrd;
        logic [31:0] wpc;
        ya = youngest_age(bus.dec_ra_idx_i, 1'b1);
        yb = youngest_age(bus.dec_rb_idx_i, 1'b1);
        yc = youngest_age(bus.dec_rc_idx_i, bus.dec_rc_used_i);
        st = (ya < N) || (yb < N) || (yc < N);
        found = 1'b0;
        wrd = 5'd0;
        wpc = 32'd0;
        foreach (q[i]) begin
            if (q[i].age == N) begin
                found = 1'b1;
                wrd   = q[i].rd;
                wpc   = q[i].pc;
            end
        end
        chk("rnd_stall", {31'd0, bus.stall_o}, {31'd0, st});
        chk("rnd_byp_a", {31'd0, bus.byp_a_o}, {31'd0, !st && ya == N});
        chk("rnd_byp_b", {31'd0, bus.byp_b_o}, {31'd0, !st && yb == N});
        chk("rnd_byp_c", {31'd0, bus.byp_c_o}, {31'd0, !st && yc == N});
        chk("rnd_wb_valid", {31'd0, bus.wb_valid_o}, {31'd0, found && wrd != 5'd0});
        if (found) begin
            chk("rnd_wb_rd", {27'd0, bus.wb_rd_idx_o}, {27'd0, wrd});
            chk("rnd_wb_pc", bus.wb_pc_o, wpc);
        end
        chk("rnd_wb_value", bus.wb_value_o, bus.mult_value_i);
        chk("rnd_inflight", {30'd0, inflight}, q.size());
        chk("rnd_stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic model_edge();
        op_t nq[$];
        op_t o;
        bit  st;
        st = (youngest_age(bus.dec_ra_idx_i, 1'b1) < N) ||
             (youngest_age(bus.dec_rb_idx_i, 1'b1) < N) ||
             (youngest_age(bus.dec_rc_idx_i, bus.dec_rc_used_i) < N);
        if (!hold) begin
            if (st) m_cnt = m_cnt + 32'd1;
            foreach (q[i]) begin
                if (q[i].age < N) begin
                    o = q[i];
                    o.age = o.age + 1;
                    nq.push_back(o);
                end
            end
            if (bus.issue_valid_i) begin
                o.rd  = bus.issue_rd_idx_i;
                o.pc  = bus.issue_pc_i;
                o.age = 1;
                nq.push_back(o);
            end
            q = nq;
        end
        if (flush) q.delete();
    endtask

    logic [31:0] saved_cnt;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_wb_valid", {31'd0, bus.wb_valid_o}, 32'd0);
        chk("rst_wb_rd", {27'd0, bus.wb_rd_idx_o}, 32'd0);
        chk("rst_wb_pc", bus.wb_pc_o, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_byp", {29'd0, bus.byp_a_o, bus.byp_b_o, bus.byp_c_o}, 32'd0);
        chk("rst_inflight", {30'd0, inflight}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        //          iv rd     pc         ra     rb     rc     rcu mv          wb rd   pc          st ba bb bc inf
        vecs[0]  = '{1'b1, 5'd5, 32'h100, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd0, 1'b0, 32'h1234, 1'b1, 5'd5, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 5'd7, 32'h200, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,   5'd7, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,   5'd7, 5'd0, 5'd0, 1'b0, 32'habcd, 1'b1, 5'd7, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[7]  = '{1'b1, 5'd3, 32'h300, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 5'd3, 32'h304, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd3, 5'd0, 1'b0, 32'h9,    1'b1, 5'd3, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd3, 5'd0, 1'b0, 32'h77,   1'b1, 5'd3, 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[11] = '{1'b1, 5'd0, 32'h400, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd0, 1'b0, 32'h5,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[14] = '{1'b1, 5'd9, 32'h500, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd9, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[16] = '{1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 5'd9, 1'b1, 32'h55,   1'b1, 5'd9, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};

        for (int i = 0; i < 17; i++) begin
            bus.issue_valid_i  = vecs[i].iv;
            bus.issue_rd_idx_i = vecs[i].rd;
            bus.issue_pc_i     = vecs[i].pc;
            bus.dec_ra_idx_i   = vecs[i].ra;
            bus.dec_rb_idx_i   = vecs[i].rb;
            bus.dec_rc_idx_i   = vecs[i].rc;
            bus.dec_rc_used_i  = vecs[i].rcu;
            bus.mult_value_i   = vecs[i].mv;
            #1;
            chk($sformatf("vec%0d_wb_valid", i), {31'd0, bus.wb_valid_o}, {31'd0, vecs[i].e_wb});
            if (vecs[i].e_wb) begin
                chk($sformatf("vec%0d_wb_rd", i), {27'd0, bus.wb_rd_idx_o}, {27'd0, vecs[i].e_rd});
                chk($sformatf("vec%0d_wb_pc", i), bus.wb_pc_o, vecs[i].e_pc);
            end
            chk($sformatf("vec%0d_stall", i), {31'd0, bus.stall_o}, {31'd0, vecs[i].e_st});
            chk($sformatf("vec%0d_byp", i), {29'd0, bus.byp_a_o, bus.byp_b_o, bus.byp_c_o},
                {29'd0, vecs[i].e_ba, vecs[i].e_bb, vecs[i].e_bc});
            chk($sformatf("vec%0d_wb_value", i), bus.wb_value_o, vecs[i].mv);
            chk($sformatf("vec%0d_byp_value", i), bus.byp_value_o, vecs[i].mv);
            chk($sformatf("vec%0d_inflight", i), {30'd0, inflight}, {30'd0, vecs[i].e_inf});
            tick();
        end
        idle_inputs();
        #1;
        chk("vec_stall_cnt", stall_cnt, 32'd2);
        tick();
        tick();

        // Hold then flush-under-hold kills the in-flight op.
        bus.issue_valid_i  = 1'b1;
        bus.issue_rd_idx_i = 5'd6;
        bus.issue_pc_i     = 32'h600;
        tick();
        bus.issue_valid_i = 1'b0;
        bus.dec_ra_idx_i  = 5'd6;
        hold = 1'b1;
        #1;
        chk("hold_inflight", {30'd0, inflight}, 32'd1);
        chk("hold_stall", {31'd0, bus.stall_o}, 32'd1);
        saved_cnt = stall_cnt;
        tick();
        chk("hold_cnt_frozen", stall_cnt, saved_cnt);
        chk("hold_inflight2", {30'd0, inflight}, 32'd1);
        bus.dec_ra_idx_i = 5'd0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_inflight", {30'd0, inflight}, 32'd0);
        tick();
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_no_wb", {31'd0, bus.wb_valid_o}, 32'd0);
            tick();
        end

        // Asynchronous reset with two ops in flight.
        bus.issue_valid_i  = 1'b1;
        bus.issue_rd_idx_i = 5'd10;
        bus.issue_pc_i     = 32'h700;
        tick();
        bus.issue_rd_idx_i = 5'd11;
        bus.issue_pc_i     = 32'h704;
        tick();
        bus.issue_valid_i = 1'b0;
        bus.dec_ra_idx_i  = 5'd11;
        #1;
        chk("pre_rst_stall", {31'd0, bus.stall_o}, 32'd1);
        chk("pre_rst_inflight", {30'd0, inflight}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", {31'd0, bus.wb_valid_o}, 32'd0);
        chk("mid_rst_wb_rd", {27'd0, bus.wb_rd_idx_o}, 32'd0);
        chk("mid_rst_wb_pc", bus.wb_pc_o, 32'd0);
        chk("mid_rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("mid_rst_inflight", {30'd0, inflight}, 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.dec_ra_idx_i = 5'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_no_wb", {31'd0, bus.wb_valid_o}, 32'd0);
            tick();
        end

        // Stall counter wrap from an all-ones preload.
        bus.issue_valid_i  = 1'b1;
        bus.issue_rd_idx_i = 5'd12;
        bus.issue_pc_i     = 32'h800;
        tick();
        bus.issue_valid_i = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        bus.dec_ra_idx_i = 5'd12;
        #1;
        chk("wrap_stall", {31'd0, bus.stall_o}, 32'd1);
        chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", stall_cnt, 32'd0);

        // Randomized traffic against the op-queue model.
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        q.delete();
        m_cnt = 32'd0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            bus.issue_valid_i  = ($urandom_range(0, 1) == 1);
            bus.issue_rd_idx_i = 5'($urandom_range(0, 3));
            bus.issue_pc_i     = $urandom;
            bus.dec_ra_idx_i   = 5'($urandom_range(0, 3));
            bus.dec_rb_idx_i   = 5'($urandom_range(0, 3));
            bus.dec_rc_idx_i   = 5'($urandom_range(0, 3));
            bus.dec_rc_used_i  = ($urandom_range(0, 1) == 1);
            bus.mult_value_i   = $urandom;
            hold               = ($urandom_range(0, 4) == 0);
            flush              = ($urandom_range(0, 9) == 0);
            #1;
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
